// File: rtl/rom_burst_reader_if.sv
// ROM read bus plus byte-stream handshake used by rom_burst_reader.
// master = burst reader, slave = ROM/consumer side.
interface rom_burst_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_en;
    logic              mem_ce;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output mem_addr,
        output mem_read_en,
        output mem_ce,
        input  mem_data,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_read_en,
        input  mem_ce,
        output mem_data,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rom_burst_reader.sv
// Walks a wrap-around ROM address range and streams each byte
// through a single registered valid/ready output stage.
module rom_burst_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    rom_burst_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] ONE = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              fetch;
    logic              xfer;

    // Refill the output stage whenever it is empty or being emptied.
    assign fetch = (state_q == READ) && (!out_valid_q || bus.out_ready);
    assign xfer  = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        cur_addr_d  = start_addr;
                        remaining_d = length;
                        state_d     = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (fetch) begin
                    out_data_d  = bus.mem_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == ONE);
                    cur_addr_d  = cur_addr_q + 1'b1;
                    remaining_d = remaining_q - ONE;
                    if (remaining_q == ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign bus.mem_addr    = cur_addr_q;
    assign bus.mem_ce      = fetch;
    assign bus.mem_read_en = fetch;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader: table of bursts checked
// against a behavioural ROM, plus reset and zero-length sequences.
module tb_rom_burst_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;
    logic [7:0] rom [256];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rom_burst_reader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    assign bus.mem_data = rom[bus.mem_addr];

    rom_burst_reader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    typedef struct {
        logic [7:0]  sa;
        logic [8:0]  len;
        logic [15:0] pat;
        int          busy_c;
        int          exp_done_c;
        logic [7:0]  exp_first;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic run_burst(input vec_t v);
        int k = 0;
        int dones = 0;
        int first_v = -1;
        int done_c = -1;
        int post = 0;
        int budget;
        logic [7:0] exp_addr;
        logic [7:0] a;
        logic [7:0] first_b = 8'h00;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       prev_last = 1'b0;
        budget = 3 * int'(v.len) + 20;
        @(negedge clk);
        start = 1'b1;
        start_addr = v.sa;
        length = v.len;
        bus.out_ready = v.pat[0];
        @(negedge clk);
        exp_addr = v.sa;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) @(negedge clk);
            bus.out_ready = v.pat[c % 16];
            start = (c == v.busy_c);
            if (c == v.busy_c) begin
                start_addr = 8'h40;
                length = 9'd2;
            end
            #1;
            if (prev_stall) begin
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_last", bus.out_last, prev_last);
            end
            chk("read_en_eq_ce", bus.mem_read_en, bus.mem_ce);
            if (bus.mem_ce) begin
                chk("mem_addr", bus.mem_addr, exp_addr);
                exp_addr = exp_addr + 8'd1;
            end
            if (bus.out_valid && first_v < 0) first_v = c;
            if (bus.out_valid && !bus.out_ready)
                chk("stall_ce", bus.mem_ce, 0);
            if (bus.out_valid && bus.out_ready) begin
                a = v.sa + 8'(k);
                if (k == 0) first_b = bus.out_data;
                chk("data", bus.out_data, rom[a]);
                chk("last", bus.out_last, int'(k == int'(v.len) - 1));
                k++;
            end
            if (done) begin
                dones++;
                done_c = c;
                chk("busy_at_done", busy, 0);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_last = bus.out_last;
            if (dones > 0) post++;
            if (post > 3) break;
        end
        start = 1'b0;
        chk("done_count", dones, 1);
        chk("byte_count", k, int'(v.len));
        chk("first_valid_cycle", first_v, 1);
        chk("first_byte", first_b, v.exp_first);
        if (v.exp_done_c > 0) chk("done_cycle", done_c, v.exp_done_c);
    endtask

    vec_t vecs [6];

    initial begin
        int k;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hC3;
        rom[8'h10] = 8'hA0;
        rom[8'h11] = 8'hA1;
        rom[8'h12] = 8'hA2;
        rom[8'h13] = 8'hA3;

        vecs[0] = '{8'h10, 9'd4,   16'hFFFF, -1, 5,   8'hA0};
        vecs[1] = '{8'h10, 9'd4,   16'hAAA9, -1, 10,  8'hA0};
        vecs[2] = '{8'hFE, 9'd4,   16'hFFFF, -1, 5,   8'h3D};
        vecs[3] = '{8'h00, 9'd256, 16'hFFFF, -1, 257, 8'hC3};
        vecs[4] = '{8'h50, 9'd8,   16'hFFFF, 3,  9,   8'h93};
        vecs[5] = '{8'hF0, 9'd300, 16'hB6DB, -1, 0,   8'h33};

        rst_n = 1'b0;
        start = 1'($urandom_range(0, 1));
        start_addr = 8'($urandom_range(0, 255));
        length = 9'($urandom_range(0, 511));
        bus.out_ready = 1'($urandom_range(0, 1));
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_ce", bus.mem_ce, 0);
        chk("rst_read_en", bus.mem_read_en, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_addr", bus.mem_addr, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("idle_ce", bus.mem_ce, 0);
            chk("idle_valid", bus.out_valid, 0);
        end

        foreach (vecs[i]) run_burst(vecs[i]);

        @(negedge clk);
        start = 1'b1;
        start_addr = 8'h33;
        length = 9'd0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", done, 1);
        chk("zero_valid", bus.out_valid, 0);
        chk("zero_ce", bus.mem_ce, 0);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("zero_done_clr", done, 0);
        chk("zero_ce2", bus.mem_ce, 0);
        chk("zero_valid2", bus.out_valid, 0);

        @(negedge clk);
        start = 1'b1;
        start_addr = 8'h80;
        length = 9'd10;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            #1;
            if (bus.out_valid && bus.out_ready) k++;
            @(negedge clk);
        end
        chk("mid_bytes_before_rst", k, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_last", bus.out_last, 0);
        chk("mid_rst_ce", bus.mem_ce, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_addr", bus.mem_addr, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("mid_rst_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_done", done, 0);
        run_burst('{8'h20, 9'd3, 16'hFFFF, -1, 4, 8'hE3});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Sequential read initiator for the 256 x 8 combinational ROM (address / read_en / ce in, data out). On a start command it walks a contiguous, wrap-around address range. It streams each byte to a downstream consumer over a valid/ready handshake with a single registered output stage, at up to one byte per clock. It sits between a control/sequencer block and any byte-stream sink that needs ROM contents.

## Interface
- ADDR_W, 8, ROM address width; depth is 2^ADDR_W.
- DATA_W, 8, ROM data and stream width.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- start_addr  input  ADDR_W  first ROM address of the burst.
- length  input  ADDR_W+1  number of bytes to read, 0..511.
- mem_addr  output  ADDR_W  ROM address.
- mem_read_en  output  1  ROM read enable.
- mem_ce  output  1  ROM chip enable.
- mem_data  input  DATA_W  ROM data, combinational from mem_addr.
- out_data  output  DATA_W  stream byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte this cycle.
- out_last  output  1  qualifies the final byte of the burst.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

## Operation
- States:
  - IDLE: busy=0.
  - READ: addresses still to issue.
  - DRAIN: last byte issued, waiting for acceptance.
- IDLE, start=1, length!=0:
  - Latch cur_addr=start_addr and remaining=length.
  - Go to READ.
  - busy=1 from the next cycle.
- IDLE, start=1, length=0:
  - No ROM access and no stream byte.
  - done=1 for one cycle, after the sampling edge.
  - Stay in IDLE.
- start while busy is ignored; no queuing.
- READ, fetch condition is (!out_valid | out_ready):
  - mem_ce=1 and mem_read_en=1 combinationally.
  - mem_addr=cur_addr.
  - At the edge:
    - out_data<=mem_data
    - out_valid<=1
    - out_last<=(remaining==1)
    - cur_addr<=cur_addr+1 modulo 2^ADDR_W (0xFF wraps to 0x00)
    - remaining<=remaining-1
  - If remaining==1, go to DRAIN.
- READ, fetch condition false: mem_ce=0 and mem_read_en=0. mem_addr holds cur_addr.
- Handshake:
  - A byte transfers on an edge with out_valid & out_ready.
  - out_valid with no fetch refill drops to 0 after the transfer.
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
- DRAIN: mem_ce=0 and mem_read_en=0. On the transfer edge:
  - out_valid<=0 and out_last<=0.
  - busy<=0 and done<=1 for one cycle.
  - Go to IDLE.
- Lengths above 2^ADDR_W re-read wrapped addresses; there is no error.
- rst_n low at any time, including mid-burst:
  - state=IDLE.
  - Outputs: busy, done, out_valid, out_last, mem_ce, mem_read_en = 0; out_data and mem_addr = 0.
  - Internal counters are cleared.
  - The partial burst is abandoned with no done pulse.

## Timing
- Start sampled at edge E0: mem_ce is asserted in the cycle after E0.
- First out_valid=1 after E1, i.e. 2 edges of latency from the start sample.
- With out_ready held at 1, a burst of N bytes:
  - valid is continuous for N cycles.
  - done is high in the cycle after the last transfer, which is E(N+1).
  - A new start is accepted from that cycle onward.
- Backpressure: out_ready=0 stalls with no ROM access. There is no lost and no duplicated byte.
- mem_ce, mem_read_en and mem_addr depend only on registered state and out_ready; they have no path from start.
- Reset assert is asynchronous. Release is synchronous to clk: the first start can be sampled on the first edge after rst_n rises.

## Test plan
- Reset values:
  - Drive rst_n=0 with random inputs.
  - Required: all outputs 0, busy=0.
  - Release, idle 5 cycles: mem_ce stays 0 and out_valid stays 0.
- Basic burst:
  - ROM[0x10..0x13] = 0xA0..0xA3, start_addr=0x10, length=4, out_ready=1.
  - Required: bytes A0, A1, A2, A3 on 4 consecutive cycles, first valid 2 edges after start.
  - out_last only on A3; done pulses once, the cycle after.
- Backpressure:
  - Same burst, with out_ready toggling 1,0,0,1,0,1,...
  - Required: exactly A0..A3 in order, each held stable while stalled.
  - mem_ce=0 during stall cycles.
- Address wrap:
  - start_addr=0xFE, length=4.
  - Required: mem_addr sequence FE, FF, 00, 01; data matches ROM.
  - length=256 from 0x00 returns all 256 entries once.
- Zero length and busy start:
  - Case 1: length=0. Required: done pulse only; no valid, no mem_ce.
  - Case 2: start with length=2 pulsed mid-burst of 8. Required: exactly 8 bytes, one done pulse.
- Reset mid-burst:
  - Assert rst_n=0 after 3 of 10 bytes.
  - Required: outputs 0 immediately, no done.
  - Required: a new burst after release reads correctly from its own start_addr.
